uart_io_ctrl: RTL and testbench
===============================

Name: uart_io_ctrl

Overview:
Sequences the UART resource for the execution core. It converts the core's word-level out/in requests (uart_wenable/uart_wd/uart_wdone, uart_renable/uart_rd/uart_rdone) into byte streams for the byte-level UART transmitter and receiver. TX and RX bytes are buffered in FIFOs, so the core stalls only when the TX buffer is full or the RX data has not yet arrived. It sits between the exec stage and the uart_tx/uart_rx PHY modules.

Parameters:
TX_DEPTH_LOG2, 4, TX FIFO depth = 2**TX_DEPTH_LOG2 bytes
RX_DEPTH_LOG2, 9, RX FIFO depth = 2**RX_DEPTH_LOG2 bytes

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
uart_wenable  in  1  one-cycle write request from the core
uart_wd  in  32  write data; only [7:0] is transmitted
uart_wdone  out  1  one-cycle pulse: write byte accepted into the TX FIFO
uart_renable  in  1  one-cycle read request from the core
uart_rword  in  1  qualifies uart_renable: 1 = 4-byte word read, 0 = byte read
uart_rdone  out  1  one-cycle pulse: uart_rd is valid
uart_rd  out  32  read result
tx_data  out  8  byte to the transmitter
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  transmitter accepts tx_data this cycle
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe: rx_data is valid
rx_overflow  out  1  sticky: a received byte was dropped

Behaviour:
- Reset: all outputs are 0. Both FIFOs are emptied. Read and write FSMs go to IDLE. Any pending request is discarded and gets no done pulse. rx_overflow is cleared.
- TX FIFO:
  - Push condition: the pending write is active and the FIFO is not full at the start of the cycle. A pop in the same cycle does not free a slot for that cycle's push.
  - Pop on tx_valid && tx_ready.
  - tx_data is the head byte and is stable while tx_valid=1 and tx_ready=0.
- Write FSM (W_IDLE, W_PEND):
  - In W_IDLE, uart_wenable latches uart_wd[7:0] and moves to W_PEND.
  - In W_PEND, push when allowed. uart_wdone pulses the cycle after the push, then the FSM returns to W_IDLE.
  - Minimum latency: wenable at edge T, push at edge T+1, wdone high in the cycle after edge T+1.
  - uart_wenable in W_PEND is a protocol violation (the core stalls until done). It is ignored, and the bench flags it.
- RX FIFO:
  - Push on rx_valid when not full.
  - rx_valid while full drops the byte and sets rx_overflow, which holds until reset.
  - A simultaneous push and pop is legal; count is unchanged.
- Read FSM (R_IDLE, R_COLLECT, R_DONE):
  - In R_IDLE, uart_renable latches uart_rword, sets need = 1 or 4, clears the shift register, and moves to R_COLLECT.
  - In R_COLLECT, pop one byte per cycle while the FIFO is non-empty.
  - Byte mode: result = {24'h0, byte}.
  - Word mode: little-endian; the k-th byte popped (k=0..3) goes to [8k+7:8k].
  - After the last pop, go to R_DONE. There, uart_rd is driven, uart_rdone pulses for one cycle, and the FSM returns to R_IDLE.
  - uart_rd holds its value until the next rdone.
  - If the FIFO goes empty mid-word, collection waits indefinitely; there is no timeout.
- Done arbitration: the core treats uart_rdone || uart_wdone as a single completion, so the two are never high in the same cycle. On a collision, rdone goes first and wdone is delayed one cycle (the W_PEND ack is held).
- Counters: FIFO pointers are DEPTH_LOG2 bits wide and wrap naturally. The count is DEPTH_LOG2+1 bits. full = count==2**DEPTH_LOG2, empty = count==0.

Decomposition:
- Package uart_io_pkg holds: the write-state enum (W_IDLE, W_PEND), the read-state enum (R_IDLE, R_COLLECT, R_DONE), BYTES_PER_WORD=4, and the byte-mode need constant 1.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH_LOG2; ports push/pop/din/dout/full/empty). It is instantiated twice: TX with WIDTH 8, RX with WIDTH 8.

Test Plan:
- Single write: wenable with wd=32'h1234_5641, tx_ready=1 → wdone pulses once 2 cycles after the request; tx_data=8'h41 with tx_valid=1; the FIFO is empty afterwards.
- TX full stall: tx_ready=0 and 16 writes of bytes 0x00..0x0F, then a 17th write 0xAA → no wdone until tx_ready rises; then wdone pulses, and output order is 0x00..0x0F followed by 0xAA.
- Word read: rx bytes 0x78,0x56,0x34,0x12 are preloaded, then renable with rword=1 → rdone pulses with uart_rd=32'h1234_5678, 5 cycles after the request.
- Byte read before data: renable with rword=0 on an empty FIFO, then rx_valid 0xC3 ten cycles later → rdone with uart_rd=32'h0000_00C3 and no earlier pulse.
- Collision: a write and a read are timed to complete in the same cycle → rdone in cycle N, wdone in cycle N+1, never both high together.
- Overflow and reset: 513 rx bytes with no reads → rx_overflow=1 and the 513th byte is lost. Asserting rstn=0 during R_COLLECT → no rdone, all outputs 0, FIFOs empty.

Source files
------------

// File: rtl/uart_io_pkg.sv
// Shared types and constants for the UART request sequencer.
package uart_io_pkg;

    typedef enum logic {
        W_IDLE,
        W_PEND
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_COLLECT,
        R_DONE
    } r_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned NEED_BYTE      = 1;

endpackage

// File: rtl/uart_io_ctrl_sync_fifo.sv
// Single-clock FIFO with a fall-through head; dout reads 0 while empty.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    // Full is judged at the start of the cycle, so a same-cycle pop never frees the push slot.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// Turns core word/byte UART requests into buffered byte streams for the TX/RX PHYs.
module uart_io_ctrl
    import uart_io_pkg::*;
#(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 9
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_wenable,
    input  logic [31:0] uart_wd,
    output logic        uart_wdone,
    input  logic        uart_renable,
    input  logic        uart_rword,
    output logic        uart_rdone,
    output logic [31:0] uart_rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_overflow
);
    w_state_t    r_wstate;
    w_state_t    w_wstate_next;
    logic [7:0]  r_wbyte;
    logic        r_wack;
    logic        w_tx_push;
    logic        w_tx_full;
    logic        w_tx_empty;

    r_state_t    r_rstate;
    r_state_t    w_rstate_next;
    logic [2:0]  r_need;
    logic [2:0]  r_got;
    logic [31:0] r_shift;
    logic [31:0] w_shift_next;
    logic [31:0] r_rd;
    logic        r_rx_overflow;
    logic        w_rx_pop;
    logic        w_last;
    logic [7:0]  w_rx_dout;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic        w_unused_wd;

    assign w_unused_wd = ^uart_wd[31:8];

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_tx_push),
        .i_pop   (tx_valid && tx_ready),
        .i_din   (r_wbyte),
        .o_dout  (tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (rx_valid),
        .i_pop   (w_rx_pop),
        .i_din   (rx_data),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    assign tx_valid    = !w_tx_empty;
    assign uart_rd     = r_rd;
    assign rx_overflow = r_rx_overflow;

    // Write path: push once, then hold the ack until rdone is not using the completion slot.
    always_comb begin
        w_wstate_next = r_wstate;
        w_tx_push     = 1'b0;
        uart_wdone    = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (uart_wenable) begin
                    w_wstate_next = W_PEND;
                end
            end
            W_PEND: begin
                w_tx_push  = !r_wack && !w_tx_full;
                uart_wdone = r_wack && (r_rstate != R_DONE);
                if (uart_wdone) begin
                    w_wstate_next = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wstate <= W_IDLE;
            r_wbyte  <= '0;
            r_wack   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_next;
            if (r_wstate == W_IDLE && uart_wenable) begin
                r_wbyte <= uart_wd[7:0];
            end
            if (w_tx_push) begin
                r_wack <= 1'b1;
            end else if (uart_wdone) begin
                r_wack <= 1'b0;
            end
        end
    end

    // Read path: little-endian collection, one byte per cycle while data is available.
    always_comb begin
        w_rstate_next = r_rstate;
        w_rx_pop      = 1'b0;
        uart_rdone    = 1'b0;
        w_last        = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (uart_renable) begin
                    w_rstate_next = R_COLLECT;
                end
            end
            R_COLLECT: begin
                w_rx_pop = !w_rx_empty;
                w_last   = w_rx_pop && ((r_got + 3'd1) == r_need);
                if (w_last) begin
                    w_rstate_next = R_DONE;
                end
            end
            R_DONE: begin
                uart_rdone    = 1'b1;
                w_rstate_next = R_IDLE;
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_shift_next = r_shift;
        w_shift_next[{r_got[1:0], 3'b000} +: 8] = w_rx_dout;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rstate      <= R_IDLE;
            r_need        <= '0;
            r_got         <= '0;
            r_shift       <= '0;
            r_rd          <= '0;
            r_rx_overflow <= 1'b0;
        end else begin
            r_rstate <= w_rstate_next;
            if (r_rstate == R_IDLE && uart_renable) begin
                r_need  <= uart_rword ? 3'(BYTES_PER_WORD) : 3'(NEED_BYTE);
                r_got   <= '0;
                r_shift <= '0;
            end
            if (w_rx_pop) begin
                r_shift <= w_shift_next;
                r_got   <= r_got + 3'd1;
                if (w_last) begin
                    r_rd <= w_shift_next;
                end
            end
            if (rx_valid && w_rx_full) begin
                r_rx_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl with a queue-based reference model checked every cycle.
module tb_uart_io_ctrl;
    localparam int TXD = 16;
    localparam int RXD = 512;

    logic        clk = 1'b0;
    logic        rstn;
    logic        uart_wenable;
    logic [31:0] uart_wd;
    logic        uart_wdone;
    logic        uart_renable;
    logic        uart_rword;
    logic        uart_rdone;
    logic [31:0] uart_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overflow;

    always #5 clk = ~clk;

    uart_io_ctrl #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(9)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .uart_wenable (uart_wenable),
        .uart_wd      (uart_wd),
        .uart_wdone   (uart_wdone),
        .uart_renable (uart_renable),
        .uart_rword   (uart_rword),
        .uart_rdone   (uart_rdone),
        .uart_rd      (uart_rd),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_overflow  (rx_overflow)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int w_pulses = 0;
    int r_pulses = 0;
    int last_wd_cyc = -1;
    int last_rd_cyc = -1;
    logic [7:0] tx_seen[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte queues plus request bookkeeping.
    logic [7:0]  m_txq[$];
    logic [7:0]  m_rxq[$];
    bit          m_valid = 1'b0;
    bit          m_wpend, m_wack;
    logic [7:0]  m_wbyte;
    bit          m_rbusy, m_rready;
    int          m_need, m_got;
    logic [31:0] m_acc, m_rd;
    bit          m_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        bit rdone_now, wdone_now, tx_full0, rx_full0;
        logic [7:0] b;
        if (!rstn) begin
            m_txq.delete();
            m_rxq.delete();
            m_wpend = 0; m_wack = 0; m_wbyte = '0;
            m_rbusy = 0; m_rready = 0; m_need = 0; m_got = 0;
            m_acc = '0; m_rd = '0; m_ovf = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            rdone_now = m_rready;
            wdone_now = m_wpend && m_wack && !rdone_now;
            tx_full0  = (m_txq.size() == TXD);
            rx_full0  = (m_rxq.size() == RXD);
            if (uart_wenable && m_wpend) begin
                errors++;
                $display("FAIL protocol: wenable while write pending (cycle %0d)", cyc);
            end
            if (m_txq.size() > 0 && tx_ready) void'(m_txq.pop_front());
            if (m_wpend && !m_wack && !tx_full0) begin
                m_txq.push_back(m_wbyte);
                m_wack = 1;
            end else if (wdone_now) begin
                m_wpend = 0;
                m_wack  = 0;
            end else if (!m_wpend && uart_wenable) begin
                m_wpend = 1;
                m_wbyte = uart_wd[7:0];
            end
            if (rdone_now) begin
                m_rready = 0;
            end else if (m_rbusy) begin
                if (m_rxq.size() > 0) begin
                    b = m_rxq.pop_front();
                    m_acc = m_acc | (32'(b) << (8 * m_got));
                    m_got++;
                    if (m_got == m_need) begin
                        m_rd = m_acc;
                        m_rbusy = 0;
                        m_rready = 1;
                    end
                end
            end else if (uart_renable) begin
                m_rbusy = 1;
                m_need  = uart_rword ? 4 : 1;
                m_got   = 0;
                m_acc   = '0;
            end
            if (rx_valid) begin
                if (rx_full0) m_ovf = 1;
                else m_rxq.push_back(rx_data);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("rdone", uart_rdone, m_rready);
            chk("wdone", uart_wdone, m_wpend && m_wack && !m_rready);
            chk("tx_valid", tx_valid, m_txq.size() > 0);
            if (m_txq.size() > 0) chk("tx_data", tx_data, m_txq[0]);
            chk("uart_rd", uart_rd, m_rd);
            chk("rx_overflow", rx_overflow, m_ovf);
            chk("done_exclusive", uart_rdone && uart_wdone, 0);
            if (uart_rdone) begin r_pulses++; last_rd_cyc = cyc; end
            if (uart_wdone) begin w_pulses++; last_wd_cyc = cyc; end
            if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] d, output int lat);
        uart_wenable = 1'b1;
        uart_wd = d;
        tick();
        uart_wenable = 1'b0;
        lat = 1;
        while (!uart_wdone && lat < 100) begin tick(); lat++; end
        tick();
    endtask

    task automatic do_read(input logic rw, output int lat, output logic [31:0] rd);
        uart_renable = 1'b1;
        uart_rword = rw;
        tick();
        uart_renable = 1'b0;
        lat = 1;
        while (!uart_rdone && lat < 100) begin tick(); lat++; end
        rd = uart_rd;
        tick();
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        int lat, c0, wp0, rp0;
        logic [31:0] rd, expw;
        logic [7:0] exp_bytes[$];

        rstn = 1'b0; uart_wenable = 0; uart_wd = '0; uart_renable = 0; uart_rword = 0;
        tx_ready = 0; rx_data = '0; rx_valid = 0;
        repeat (3) tick();
        rstn = 1'b1;
        chk("reset wdone", uart_wdone, 0);
        chk("reset rdone", uart_rdone, 0);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset rd", uart_rd, 0);
        chk("reset overflow", rx_overflow, 0);
        $display("reset released");

        // Single write
        tx_ready = 1'b1;
        uart_wenable = 1'b1; uart_wd = 32'h1234_5641;
        tick();
        uart_wenable = 1'b0;
        chk("single write early wdone", uart_wdone, 0);
        tick();
        chk("single write wdone", uart_wdone, 1);
        chk("single write tx_valid", tx_valid, 1);
        chk("single write tx_data", tx_data, 8'h41);
        tick();
        chk("single write fifo empty", tx_valid, 0);
        $display("write 0x41 done");

        // TX full stall
        tx_ready = 1'b0;
        tx_seen.delete();
        for (int i = 0; i < 16; i++) begin
            do_write(32'(i), lat);
            chk("fill write latency", lat, 2);
        end
        wp0 = w_pulses;
        uart_wenable = 1'b1; uart_wd = 32'hFFFF_FFAA;
        tick();
        uart_wenable = 1'b0;
        repeat (20) tick();
        chk("stall no wdone", w_pulses - wp0, 0);
        tx_ready = 1'b1;
        lat = 0;
        while (!uart_wdone && lat < 100) begin tick(); lat++; end
        chk("stall released wdone", uart_wdone, 1);
        tick();
        repeat (25) tick();
        for (int i = 0; i < 16; i++) exp_bytes.push_back(8'(i));
        exp_bytes.push_back(8'hAA);
        chk("tx drained count", tx_seen.size(), 17);
        for (int i = 0; i < 17 && i < tx_seen.size(); i++) chk("tx order", tx_seen[i], exp_bytes[i]);
        $display("tx full stall: %0d bytes drained", tx_seen.size());

        // Word read
        rx_send(8'h78); rx_send(8'h56); rx_send(8'h34); rx_send(8'h12);
        do_read(1'b1, lat, rd);
        chk("word read latency", lat, 5);
        chk("word read data", rd, 32'h1234_5678);
        $display("word read %h latency %0d", rd, lat);

        // Byte read before data
        rp0 = r_pulses;
        uart_renable = 1'b1; uart_rword = 1'b0;
        tick();
        uart_renable = 1'b0;
        repeat (9) tick();
        chk("early rdone", r_pulses - rp0, 0);
        rx_send(8'hC3);
        lat = 0;
        while (!uart_rdone && lat < 100) begin tick(); lat++; end
        chk("late byte rdone", uart_rdone, 1);
        chk("late byte data", uart_rd, 32'h0000_00C3);
        tick();
        $display("byte read %h", uart_rd);

        // Collision of read and write completions
        rx_send(8'h5A);
        uart_wenable = 1'b1; uart_wd = 32'h77;
        uart_renable = 1'b1; uart_rword = 1'b0;
        tick();
        uart_wenable = 1'b0; uart_renable = 1'b0;
        c0 = cyc;
        repeat (4) tick();
        chk("collision rdone cycle", last_rd_cyc, c0 + 1);
        chk("collision wdone cycle", last_wd_cyc, c0 + 2);
        chk("collision data", uart_rd, 32'h5A);
        $display("collision rdone@%0d wdone@%0d", last_rd_cyc, last_wd_cyc);

        // Overflow
        for (int i = 0; i < 513; i++) rx_send(8'(i) ^ 8'h5A);
        chk("overflow set", rx_overflow, 1);
        for (int j = 0; j < 128; j++) begin
            expw = '0;
            for (int k = 0; k < 4; k++) expw[8*k +: 8] = 8'(4*j + k) ^ 8'h5A;
            do_read(1'b1, lat, rd);
            chk("overflow word", rd, expw);
        end
        chk("overflow sticky", rx_overflow, 1);
        $display("overflow: 128 words read back");

        // Reset during R_COLLECT (513th byte must be gone)
        rp0 = r_pulses;
        uart_renable = 1'b1; uart_rword = 1'b1;
        tick();
        uart_renable = 1'b0;
        repeat (5) tick();
        chk("dropped byte absent", r_pulses - rp0, 0);
        tx_ready = 1'b0;
        do_write(32'h3C, lat);
        chk("pre-reset tx_valid", tx_valid, 1);
        rstn = 1'b0;
        tick(); tick();
        chk("rst wdone", uart_wdone, 0);
        chk("rst rdone", uart_rdone, 0);
        chk("rst tx_valid", tx_valid, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst rd", uart_rd, 0);
        chk("rst overflow", rx_overflow, 0);
        rstn = 1'b1;
        repeat (5) tick();
        chk("no rdone after reset", r_pulses - rp0, 0);
        rx_send(8'h99);
        do_read(1'b0, lat, rd);
        chk("post reset byte", rd, 32'h99);
        $display("reset during collect handled");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
